// File: rtl/fake_n64_pkg.sv
// Shared Joybus definitions for the fake N64 controller.
//  - command byte constants and the frame length each command must arrive with
//  - sequencer state encoding (4 bits wide, same width as the tx block's state)
package fake_n64_pkg;

  localparam logic [7:0] CMD_INFO   = 8'h00;
  localparam logic [7:0] CMD_STATUS = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_WRITE  = 8'h03;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  // Byte counts include the command byte itself.
  localparam logic [5:0] LEN_INFO   = 6'd1;
  localparam logic [5:0] LEN_STATUS = 6'd1;
  localparam logic [5:0] LEN_READ   = 6'd3;  // cmd + 2 address bytes
  localparam logic [5:0] LEN_WRITE  = 6'd35; // cmd + 2 address + 32 data
  localparam logic [5:0] LEN_RESET  = 6'd1;

  typedef enum logic [3:0] {
    SEQ_RX_WAIT    = 4'd0,
    SEQ_CHECK      = 4'd1,
    SEQ_TURNAROUND = 4'd2,
    SEQ_TX         = 4'd3,
    SEQ_RECOVER    = 4'd4
  } seq_state_e;

  // Returns the required frame length for a command; 0 marks an unknown
  // command (no real frame is ever zero bytes long).
  function automatic logic [5:0] expected_len(input logic [7:0] cmd);
    case (cmd)
      CMD_INFO:   expected_len = LEN_INFO;
      CMD_STATUS: expected_len = LEN_STATUS;
      CMD_READ:   expected_len = LEN_READ;
      CMD_WRITE:  expected_len = LEN_WRITE;
      CMD_RESET:  expected_len = LEN_RESET;
      default:    expected_len = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/fake_n64_cmd_checker.sv
// Combinational frame validator.
//  cmd_i      : received command byte
//  byte_cnt_i : received byte count including the command byte
//  legal_o    : command is known and arrived with exactly its expected length
import fake_n64_pkg::*;

module fake_n64_cmd_checker (
  input  logic [7:0] cmd_i,
  input  logic [5:0] byte_cnt_i,
  output logic       legal_o
);

  logic [5:0] exp_len;

  assign exp_len = expected_len(cmd_i);
  assign legal_o = (exp_len != 6'd0) && (byte_cnt_i == exp_len);

endmodule

// File: rtl/fake_n64_link_sequencer.sv
// Joybus wire owner for the fake controller. Waits for a host frame from the
// rx deframer, validates it, waits a turnaround gap, grants the wire to the tx
// block with cmd/crc held stable, and reclaims it on the tx handoff toggle or
// on timeout.
//  sample_clk_i     : clock, all logic on posedge
//  reset_n_i        : synchronous active-low reset
//  rx_done_i        : one-cycle pulse, host frame fully received
//  rx_cmd_i         : first frame byte, valid with rx_done_i
//  rx_byte_cnt_i    : byte count incl. command, valid with rx_done_i
//  rx_data_crc_i    : payload CRC, valid with rx_done_i
//  tx_handoff_i     : toggle from tx block, each transition = response done
//  rx_enable_o      : rx deframer may sample the wire
//  cur_operation_o  : 0 = rx owns wire, 1 = tx owns wire
//  cmd_o / crc_o    : command and CRC seed for tx
//  busy_o           : high in every state except RX_WAIT
//  err_timeout_o    : one-cycle pulse on forced reclaim
//  err_count_o      : saturating count of rejected frames + timeouts
//  frames_served_o  : wrapping count of completed tx responses
import fake_n64_pkg::*;

module fake_n64_link_sequencer #(
  parameter int TURNAROUND_CYCLES = 16,
  parameter int TX_TIMEOUT        = 4096,
  parameter int RECOVER_CYCLES    = 8
) (
  input  logic        sample_clk_i,
  input  logic        reset_n_i,
  input  logic        rx_done_i,
  input  logic [7:0]  rx_cmd_i,
  input  logic [5:0]  rx_byte_cnt_i,
  input  logic [7:0]  rx_data_crc_i,
  input  logic        tx_handoff_i,
  output logic        rx_enable_o,
  output logic        cur_operation_o,
  output logic [7:0]  cmd_o,
  output logic [7:0]  crc_o,
  output logic        busy_o,
  output logic        err_timeout_o,
  output logic [7:0]  err_count_o,
  output logic [15:0] frames_served_o
);

  // Turnaround timer holds the full load value; the timeout and recover
  // timers only ever hold (limit - 1), so $clog2 of the limit is enough.
  localparam int TAW = (TURNAROUND_CYCLES > 0) ? $clog2(TURNAROUND_CYCLES + 1) : 1;
  localparam int TOW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  localparam int RCW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  localparam logic [TAW-1:0] TA_LOAD = TAW'(TURNAROUND_CYCLES);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TX_TIMEOUT - 1);
  localparam logic [RCW-1:0] RC_LOAD = RCW'(RECOVER_CYCLES - 1);

  seq_state_e     state_q, state_d;
  logic [7:0]     cmd_q, cmd_d;
  logic [7:0]     crc_q, crc_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [TAW-1:0] ta_q, ta_d;
  logic [TOW-1:0] to_q, to_d;
  logic [RCW-1:0] rc_q, rc_d;
  logic           ref_q, ref_d;
  logic           err_to_q, err_to_d;
  logic [7:0]     err_cnt_q, err_cnt_d;
  logic [15:0]    frames_q, frames_d;
  logic           legal;

  fake_n64_cmd_checker u_chk (
    .cmd_i      (cmd_q),
    .byte_cnt_i (cnt_q),
    .legal_o    (legal)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    ta_d      = ta_q;
    to_d      = to_q;
    rc_d      = rc_q;
    ref_d     = ref_q;
    err_to_d  = 1'b0;
    err_cnt_d = err_cnt_q;
    frames_d  = frames_q;
    case (state_q)
      SEQ_RX_WAIT: begin
        if (rx_done_i) begin
          cmd_d   = rx_cmd_i;
          crc_d   = rx_data_crc_i;
          cnt_d   = rx_byte_cnt_i;
          state_d = SEQ_CHECK;
        end
      end
      SEQ_CHECK: begin
        if (legal) begin
          ta_d    = TA_LOAD;
          state_d = SEQ_TURNAROUND;
        end else begin
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          state_d = SEQ_RX_WAIT;
        end
      end
      SEQ_TURNAROUND: begin
        if (ta_q == '0) begin
          ref_d   = tx_handoff_i; // level at grant is the reference for "done"
          to_d    = '0;
          state_d = SEQ_TX;
        end else begin
          ta_d = ta_q - 1'b1;
        end
      end
      SEQ_TX: begin
        // Handoff checked first so a response finishing on the timeout cycle
        // is counted as served, not as an error.
        if (tx_handoff_i != ref_q) begin
          frames_d = frames_q + 16'd1;
          rc_d     = RC_LOAD;
          state_d  = SEQ_RECOVER;
        end else if (to_q == TO_LAST) begin
          err_to_d = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          rc_d     = RC_LOAD;
          state_d  = SEQ_RECOVER;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      SEQ_RECOVER: begin
        if (rc_q == '0) state_d = SEQ_RX_WAIT;
        else            rc_d    = rc_q - 1'b1;
      end
      default: state_d = SEQ_RX_WAIT;
    endcase
  end

  always_ff @(posedge sample_clk_i) begin
    if (!reset_n_i) begin
      state_q   <= SEQ_RX_WAIT;
      cmd_q     <= 8'h00;
      crc_q     <= 8'h00;
      cnt_q     <= 6'd0;
      ta_q      <= '0;
      to_q      <= '0;
      rc_q      <= '0;
      ref_q     <= 1'b0;
      err_to_q  <= 1'b0;
      err_cnt_q <= 8'h00;
      frames_q  <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      ta_q      <= ta_d;
      to_q      <= to_d;
      rc_q      <= rc_d;
      ref_q     <= ref_d;
      err_to_q  <= err_to_d;
      err_cnt_q <= err_cnt_d;
      frames_q  <= frames_d;
    end
  end

  // Wire-ownership outputs decode straight from the state flop.
  assign rx_enable_o     = (state_q == SEQ_RX_WAIT);
  assign busy_o          = (state_q != SEQ_RX_WAIT);
  assign cur_operation_o = (state_q == SEQ_TX);
  assign cmd_o           = cmd_q;
  assign crc_o           = crc_q;
  assign err_timeout_o   = err_to_q;
  assign err_count_o     = err_cnt_q;
  assign frames_served_o = frames_q;

endmodule

// File: tb/tb_fake_n64_link_sequencer.sv
module tb_fake_n64_link_sequencer;

  localparam int T  = 16;  // turnaround
  localparam int TO = 40;  // tx timeout (short for simulation)
  localparam int R  = 8;   // recover

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_done;
  logic [7:0]  rx_cmd;
  logic [5:0]  rx_cnt;
  logic [7:0]  rx_crc;
  logic        tx_handoff;
  logic        rx_enable, cur_op, busy, err_to;
  logic [7:0]  cmd, crc, err_count;
  logic [15:0] frames;

  fake_n64_link_sequencer #(
    .TURNAROUND_CYCLES (T),
    .TX_TIMEOUT        (TO),
    .RECOVER_CYCLES    (R)
  ) dut (
    .sample_clk_i    (clk),
    .reset_n_i       (rst_n),
    .rx_done_i       (rx_done),
    .rx_cmd_i        (rx_cmd),
    .rx_byte_cnt_i   (rx_cnt),
    .rx_data_crc_i   (rx_crc),
    .tx_handoff_i    (tx_handoff),
    .rx_enable_o     (rx_enable),
    .cur_operation_o (cur_op),
    .cmd_o           (cmd),
    .crc_o           (crc),
    .busy_o          (busy),
    .err_timeout_o   (err_to),
    .err_count_o     (err_count),
    .frames_served_o (frames)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference counters kept by the bench.
  int exp_err = 0;
  int exp_frames = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Legal command/length pairs straight from the protocol table.
  function automatic bit model_legal(input logic [7:0] c, input logic [5:0] n);
    case (c)
      8'h00, 8'h01, 8'hFF: return n == 6'd1;
      8'h02:               return n == 6'd3;
      8'h03:               return n == 6'd35;
      default:             return 1'b0;
    endcase
  endfunction

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  // One full transaction. Entered just after a negedge. rx_done is sampled at
  // edge 0; k counts edges from there. d: edge offset (from tx grant) at which
  // the DUT first sees the toggled handoff; d > TO means no handoff at all.
  // spur: edge at which a stray rx_done is presented (0 = none).
  task automatic run_frame(input logic [7:0] c, input logic [5:0] n, input logic [7:0] cr,
                           input int d, input int spur, input bit legal);
    int grant, x, last;
    bit tmo;
    grant = 2 + T;
    tmo   = (d > TO);
    x     = grant + (tmo ? TO : d);
    last  = legal ? x + R : 1;
    rx_done = 1'b1; rx_cmd = c; rx_cnt = n; rx_crc = cr;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      rx_done = 1'b0;
      rx_cmd  = 8'($urandom);
      rx_crc  = 8'($urandom);
      rx_cnt  = 6'($urandom);
      if (legal) begin
        if (k == x) begin
          if (tmo) bump_err();
          else     exp_frames = (exp_frames + 1) % 65536;
        end
        chk($sformatf("cur_op k=%0d", k), 32'(cur_op), 32'(k >= grant && k < x));
        chk($sformatf("rx_enable k=%0d", k), 32'(rx_enable), 32'(k >= x + R));
        chk($sformatf("busy k=%0d", k), 32'(busy), 32'(k < x + R));
        chk($sformatf("err_timeout k=%0d", k), 32'(err_to), 32'(k == x && tmo));
      end else begin
        if (k == 1) bump_err();
        chk($sformatf("rej cur_op k=%0d", k), 32'(cur_op), 32'd0);
        chk($sformatf("rej rx_enable k=%0d", k), 32'(rx_enable), 32'(k == 1));
        chk($sformatf("rej err_timeout k=%0d", k), 32'(err_to), 32'd0);
      end
      chk($sformatf("cmd k=%0d", k), 32'(cmd), 32'(c));
      chk($sformatf("crc k=%0d", k), 32'(crc), 32'(cr));
      chk($sformatf("err_count k=%0d", k), 32'(err_count), 32'(exp_err));
      chk($sformatf("frames k=%0d", k), 32'(frames), 32'(exp_frames));
      // inputs for edge k+1
      if (legal && !tmo && k + 1 == grant + d) tx_handoff = ~tx_handoff;
      if (spur != 0 && k + 1 == spur) begin
        rx_done = 1'b1; rx_cmd = 8'h02; rx_cnt = 6'd3; rx_crc = ~cr;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " rx_enable"}, 32'(rx_enable), 32'd1);
    chk({tag, " cur_op"}, 32'(cur_op), 32'd0);
    chk({tag, " cmd"}, 32'(cmd), 32'h00);
    chk({tag, " crc"}, 32'(crc), 32'h00);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " err_timeout"}, 32'(err_to), 32'd0);
    chk({tag, " err_count"}, 32'(err_count), 32'd0);
    chk({tag, " frames"}, 32'(frames), 32'd0);
  endtask

  typedef struct {
    logic [7:0] c;
    logic [5:0] n;
    logic [7:0] cr;
    int         d;
    int         spur;
    bit         legal;   // expected validation result
  } vec_t;

  vec_t vecs[12];

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'h01, 6'd1,  8'h00, 5,      0,  1'b1}; // basic status
    vecs[1]  = '{8'h03, 6'd35, 8'hA5, 10,     20, 1'b1}; // write, crc held, stray rx in TX
    vecs[2]  = '{8'h03, 6'd34, 8'h11, 5,      0,  1'b0}; // short write
    vecs[3]  = '{8'h7E, 6'd1,  8'h22, 5,      0,  1'b0}; // unknown command
    vecs[4]  = '{8'h00, 6'd1,  8'h33, 3,      1,  1'b1}; // stray rx in CHECK
    vecs[5]  = '{8'hFF, 6'd1,  8'h44, TO,     9,  1'b1}; // handoff on timeout cycle
    vecs[6]  = '{8'h02, 6'd3,  8'h55, TO + 1, 30, 1'b1}; // timeout
    vecs[7]  = '{8'h02, 6'd2,  8'h66, 5,      0,  1'b0};
    vecs[8]  = '{8'h00, 6'd0,  8'h77, 5,      0,  1'b0};
    vecs[9]  = '{8'h01, 6'd2,  8'h88, 5,      1,  1'b0};
    vecs[10] = '{8'h02, 6'd3,  8'h99, 1,      0,  1'b1}; // earliest handoff
    vecs[11] = '{8'hFF, 6'd1,  8'hAA, 12,     0,  1'b1}; // stray rx in RECOVER
    vecs[11].spur = 2 + T + 12 + R;

    rst_n = 1'b0; rx_done = 1'b0; rx_cmd = 8'h00; rx_cnt = 6'd0; rx_crc = 8'h00;
    tx_handoff = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_frame(vecs[i].c, vecs[i].n, vecs[i].cr, vecs[i].d, vecs[i].spur, vecs[i].legal);

    // Randomized transactions against the model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] c;
      logic [5:0] n;
      int d, spur, x;
      bit lg;
      case ($urandom_range(0, 6))
        0: c = 8'h00;
        1: c = 8'h01;
        2: c = 8'h02;
        3: c = 8'h03;
        4: c = 8'hFF;
        default: c = 8'($urandom);
      endcase
      if ($urandom_range(0, 3) != 0) n = (c == 8'h02) ? 6'd3 : (c == 8'h03) ? 6'd35 : 6'd1;
      else                           n = 6'($urandom);
      lg = model_legal(c, n);
      d  = ($urandom_range(0, 4) == 0) ? TO + 1 : int'($urandom_range(1, TO));
      x  = 2 + T + ((d > TO) ? TO : d);
      spur = lg ? int'($urandom_range(0, x + R)) : int'($urandom_range(0, 1));
      run_frame(c, n, 8'($urandom), d, spur, lg);
    end

    // Reset in the middle of TX drops the wire on the next cycle.
    rx_done = 1'b1; rx_cmd = 8'h01; rx_cnt = 6'd1; rx_crc = 8'h3C;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (2 + T + 3) @(negedge clk);
    chk("midtx cur_op before reset", 32'(cur_op), 32'd1);
    chk("midtx cmd before reset", 32'(cmd), 32'h01);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("midtx reset");
    rst_n = 1'b1;
    exp_err = 0;
    exp_frames = 0;
    @(negedge clk);

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++)
      run_frame(8'h7E, 6'd1, 8'h00, 5, 0, 1'b0);
    chk("err_count saturated", 32'(err_count), 32'hFF);

    // A timeout while saturated must leave the counter at FF.
    run_frame(8'h01, 6'd1, 8'h5A, TO + 1, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
